// File: rtl/data_mem_arbiter.sv
// Two-port arbiter (CPU port A, debug/DMA port B) in front of a single synchronous RAM.
// Round-robin on ties, with a bounded bus lock for port B.
module data_mem_arbiter #(
    parameter int unsigned MAX_LOCK = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_req,
    input  logic       a_we,
    input  logic [7:0] a_addr,
    input  logic [7:0] a_wdata,
    input  logic       b_req,
    input  logic       b_we,
    input  logic [7:0] b_addr,
    input  logic [7:0] b_wdata,
    input  logic       b_lock,
    output logic       a_gnt,
    output logic       b_gnt,
    output logic       a_rvalid,
    output logic       b_rvalid,
    output logic [7:0] a_rdata,
    output logic [7:0] b_rdata,
    output logic       a_stall,
    output logic       mem_en,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(MAX_LOCK);

    typedef enum logic [1:0] {
        ARB     = 2'd0,
        LOCK_B  = 2'd1,
        FORCE_A = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               last_b_q, last_b_d;   // 1 = port B was granted last
    logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic [CNT_W-1:0]   lock_inc;
    logic               gnt_a, gnt_b;
    logic               a_pend_q, b_pend_q;

    // Saturating count of cycles B has owned the bus, including the current one.
    always_comb begin
        lock_inc = (lock_cnt_q >= LOCK_MAX) ? LOCK_MAX : lock_cnt_q + CNT_W'(1);
    end

    always_comb begin
        state_d    = state_q;
        last_b_d   = last_b_q;
        lock_cnt_d = lock_cnt_q;
        gnt_a      = 1'b0;
        gnt_b      = 1'b0;
        case (state_q)
            ARB: begin
                if (a_req && b_req) begin
                    gnt_a = last_b_q;
                    gnt_b = ~last_b_q;
                end else begin
                    gnt_a = a_req;
                    gnt_b = b_req;
                end
                if (gnt_a) begin
                    last_b_d = 1'b0;
                end else if (gnt_b) begin
                    last_b_d = 1'b1;
                end
                if (gnt_b && b_lock) begin
                    state_d    = LOCK_B;
                    lock_cnt_d = CNT_W'(1);
                end else begin
                    lock_cnt_d = '0;
                end
            end
            LOCK_B: begin
                gnt_b      = b_req;
                gnt_a      = a_req & ~b_req;
                lock_cnt_d = lock_inc;
                // Release wins over the starvation guard.
                if (!b_lock) begin
                    state_d    = ARB;
                    last_b_d   = 1'b1;
                    lock_cnt_d = '0;
                end else if ((lock_inc == LOCK_MAX) && a_req) begin
                    state_d = FORCE_A;
                end
            end
            FORCE_A: begin
                gnt_a      = a_req;
                state_d    = ARB;
                last_b_d   = 1'b0;
                lock_cnt_d = '0;
            end
            default: begin
                state_d    = ARB;
                last_b_d   = 1'b1;
                lock_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB;
            last_b_q   <= 1'b1;
            lock_cnt_q <= '0;
            a_pend_q   <= 1'b0;
            b_pend_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_b_q   <= last_b_d;
            lock_cnt_q <= lock_cnt_d;
            a_pend_q   <= gnt_a & ~a_we;
            b_pend_q   <= gnt_b & ~b_we;
        end
    end

    // Grant-path outputs are combinational but forced low while reset is asserted.
    always_comb begin
        a_gnt     = rst_n & gnt_a;
        b_gnt     = rst_n & gnt_b;
        a_stall   = rst_n & a_req & ~gnt_a;
        mem_en    = a_gnt | b_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (a_gnt) begin
            mem_we    = a_we;
            mem_addr  = a_addr;
            mem_wdata = a_wdata;
        end else if (b_gnt) begin
            mem_we    = b_we;
            mem_addr  = b_addr;
            mem_wdata = b_wdata;
        end
        a_rvalid = a_pend_q;
        b_rvalid = b_pend_q;
        a_rdata  = a_pend_q ? mem_rdata : '0;
        b_rdata  = b_pend_q ? mem_rdata : '0;
    end

endmodule
